// File: rtl/uart_pkg.sv
// Shared types for the UART transceiver: frame parity modes, FSM states,
// the receive FIFO entry layout and a parity helper.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 8;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_t;

  // Payload is stored zero-extended to MAX_DATA_BITS.
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     parity_err;
    logic                     framing_err;
  } rx_entry_t;

  // Parity bit that accompanies a zero-extended payload (NONE reports even).
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] d,
                                      input parity_mode_t m);
    return (m == PARITY_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguishable; a push into a full FIFO only succeeds when
// a pop frees the head slot in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Occupancy flags, accepted operations and next pointers.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are only observable through valid entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_transceiver.sv
// Parametrised UART transceiver: TX serialiser, RX deserialiser with a
// two-flop input synchroniser, and a receive FIFO with per-entry error flags.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned  CLOCK_FREQ    = 100_000_000,
  parameter int unsigned  BAUD_RATE     = 115_200,
  parameter int unsigned  DIVISOR       = CLOCK_FREQ / BAUD_RATE,
  parameter int unsigned  DATA_BITS     = 8,
  parameter parity_mode_t PARITY        = PARITY_NONE,
  parameter int unsigned  STOP_BITS     = 1,
  parameter int unsigned  RX_FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_tx_valid,
  output logic                 io_tx_ready,
  input  logic [DATA_BITS-1:0] io_tx_bits,
  output logic                 io_rx_valid,
  input  logic                 io_rx_ready,
  output logic [DATA_BITS-1:0] io_rx_bits,
  output logic                 io_rx_parity_error,
  output logic                 io_rx_framing_error,
  output logic                 io_rx_overrun,
  output logic                 io_out,
  input  logic                 io_in
);

  if (DIVISOR < 4) begin : g_bad_divisor
    $error("uart_transceiver: DIVISOR must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_transceiver: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_transceiver: STOP_BITS must be 1 or 2");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_transceiver: RX_FIFO_DEPTH must be a power of 2, >= 2");
  end

  localparam int unsigned CW = $clog2(2 * DIVISOR + 1);
  localparam int unsigned BW = $clog2(MAX_DATA_BITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DIV     = CW'(DIVISOR);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF    = CW'(DIVISOR / 2);
  localparam logic [CW-1:0] STOP_M1 = CW'(STOP_BITS * DIVISOR - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_out_q, tx_out_d;

  // TX next state; the line level is computed for the next state so that
  // io_out comes straight from a flop.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_sh_d     = tx_sh_q;
    tx_par_d    = tx_par_q;
    io_tx_ready = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        io_tx_ready = 1'b1;
        if (io_tx_valid) begin
          tx_sh_d    = io_tx_bits;
          tx_par_d   = parity_bit(MAX_DATA_BITS'(io_tx_bits), PARITY);
          tx_cnt_d   = DIV_M1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q - CNT_ONE;
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = DIV_M1;
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_bit_q == LAST) begin
            if (PARITY == PARITY_NONE) begin
              tx_cnt_d   = STOP_M1;
              tx_state_d = TX_STOP;
            end else tx_state_d = TX_PARITY;
          end else tx_bit_d = tx_bit_q + BIT_ONE;
        end else tx_cnt_d = tx_cnt_q - CNT_ONE;
      end
      TX_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = STOP_M1;
          tx_state_d = TX_STOP;
        end else tx_cnt_d = tx_cnt_q - CNT_ONE;
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
        else tx_cnt_d = tx_cnt_q - CNT_ONE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    unique case (tx_state_d)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = tx_sh_d[0];
      TX_PARITY: tx_out_d = tx_par_d;
      default:   tx_out_d = 1'b1;
    endcase
  end

  // TX registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign io_out = tx_out_q;

  // ---------------------------------------------------------------- RX
  logic [1:0]           sync_q;
  logic                 rxs;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_push_q, rx_push_d;
  rx_entry_t            rx_ent_q, rx_ent_d;
  rx_entry_t            head;
  logic                 fifo_full, fifo_empty;

  // Two-flop synchroniser for the asynchronous RXD line (idles high).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], io_in};
  end

  assign rxs = sync_q[1];

  // RX next state. The counter is loaded with N and a sample is taken when
  // it reads 1, i.e. N cycles after the load: half a bit for the start-bit
  // check, then one full bit period per sample.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_push_d  = 1'b0;
    rx_ent_d   = rx_ent_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rxs) begin
          rx_cnt_d   = HALF;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_ONE) begin
          if (!rxs) begin
            rx_cnt_d   = DIV;
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end else rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q - CNT_ONE;
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_ONE) begin
          rx_cnt_d = DIV;
          rx_sh_d  = {rxs, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST)
            rx_state_d = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
          else rx_bit_d = rx_bit_q + BIT_ONE;
        end else rx_cnt_d = rx_cnt_q - CNT_ONE;
      end
      RX_PARITY: begin
        if (rx_cnt_q == CNT_ONE) begin
          rx_cnt_d   = DIV;
          rx_par_d   = rxs;
          rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q - CNT_ONE;
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_ONE) begin
          rx_push_d            = 1'b1;
          rx_ent_d.data        = MAX_DATA_BITS'(rx_sh_q);
          rx_ent_d.parity_err  = (PARITY != PARITY_NONE) &&
                                 (parity_bit(MAX_DATA_BITS'(rx_sh_q), PARITY) != rx_par_q);
          rx_ent_d.framing_err = !rxs;
          rx_state_d           = rxs ? RX_IDLE : RX_BREAK_WAIT;
        end else rx_cnt_d = rx_cnt_q - CNT_ONE;
      end
      RX_BREAK_WAIT: begin
        if (rxs) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX registers; the completed entry is pushed the cycle after the stop sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_ent_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_push_q  <= rx_push_d;
      rx_ent_q   <= rx_ent_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (rx_push_q),
    .wdata_i (rx_ent_q),
    .pop_i   (io_rx_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head is masked while empty so the outputs never expose stale storage.
  always_comb begin
    io_rx_valid         = !fifo_empty;
    io_rx_bits          = io_rx_valid ? head.data[DATA_BITS-1:0] : '0;
    io_rx_parity_error  = io_rx_valid && head.parity_err;
    io_rx_framing_error = io_rx_valid && head.framing_err;
    io_rx_overrun       = rx_push_q && fifo_full && !io_rx_ready;
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: one 8N1 instance (index 0) and one 8E1
// instance (index 1), DIVISOR=10, RX FIFO depth 4. Expected line waveforms
// and received entries come from a frame-level model of the UART protocol.
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int unsigned D     = 10;
  localparam int unsigned DEPTH = 4;

  typedef logic [9:0] ent_t;  // {data, parity_err, framing_err}

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic [7:0] tx_bits  [2];
  logic       rx_valid [2];
  logic       rx_ready [2];
  logic [7:0] rx_bits  [2];
  logic       pe       [2];
  logic       fe       [2];
  logic       ovr      [2];
  logic       out_l    [2];
  logic       in_l     [2];
  logic       drv      [2];
  logic       lb;

  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt0 = 0;
  int   ovr_cnt1 = 0;
  int   exp_ovr0 = 0;
  ent_t exp_q0[$];
  ent_t exp_q1[$];

  always #5 clock = ~clock;

  assign in_l[0] = drv[0];
  assign in_l[1] = lb ? out_l[1] : drv[1];

  uart_transceiver #(
    .CLOCK_FREQ (1_000_000), .BAUD_RATE (100_000), .DATA_BITS (8),
    .PARITY (PARITY_NONE), .STOP_BITS (1), .RX_FIFO_DEPTH (DEPTH)
  ) dut_n (
    .clock (clock), .reset (reset),
    .io_tx_valid (tx_valid[0]), .io_tx_ready (tx_ready[0]), .io_tx_bits (tx_bits[0]),
    .io_rx_valid (rx_valid[0]), .io_rx_ready (rx_ready[0]), .io_rx_bits (rx_bits[0]),
    .io_rx_parity_error (pe[0]), .io_rx_framing_error (fe[0]),
    .io_rx_overrun (ovr[0]), .io_out (out_l[0]), .io_in (in_l[0])
  );

  uart_transceiver #(
    .CLOCK_FREQ (1_000_000), .BAUD_RATE (100_000), .DATA_BITS (8),
    .PARITY (PARITY_EVEN), .STOP_BITS (1), .RX_FIFO_DEPTH (DEPTH)
  ) dut_e (
    .clock (clock), .reset (reset),
    .io_tx_valid (tx_valid[1]), .io_tx_ready (tx_ready[1]), .io_tx_bits (tx_bits[1]),
    .io_rx_valid (rx_valid[1]), .io_rx_ready (rx_ready[1]), .io_rx_bits (rx_bits[1]),
    .io_rx_parity_error (pe[1]), .io_rx_framing_error (fe[1]),
    .io_rx_overrun (ovr[1]), .io_out (out_l[1]), .io_in (in_l[1])
  );

  // Overrun pulses are counted one per cycle they are seen high.
  always @(negedge clock) begin
    if (ovr[0] === 1'b1) ovr_cnt0++;
    if (ovr[1] === 1'b1) ovr_cnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Even-parity bit for a byte: 1 when the byte has an odd number of ones.
  function automatic logic even_par(input logic [7:0] d);
    return 1'(($countones(d) % 2));
  endfunction

  // Line bits in transmission order: start, 8 data LSB first, [parity], stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par_en);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (par_en) f[9] = even_par(d);
    return f;
  endfunction

  // Send one byte through the TX port and check the whole line waveform.
  task automatic tx_frame(input int s, input logic [7:0] d);
    int          n;
    int          lowcnt;
    logic        ok;
    logic [10:0] f;
    n = (s == 1) ? 11 : 10;
    f = frame_bits(d, s == 1);
    for (int i = 0; i < 300 && tx_ready[s] !== 1'b1; i++) @(negedge clock);
    chk("tx_ready_idle", 32'(tx_ready[s]), 1);
    tx_bits[s]  = d;
    tx_valid[s] = 1'b1;
    @(negedge clock);
    tx_valid[s] = 1'b0;
    lowcnt = 0;
    for (int b = 0; b < n; b++) begin
      ok = 1'b1;
      for (int c = 0; c < int'(D); c++) begin
        if (out_l[s] !== f[b]) ok = 1'b0;
        if (tx_ready[s] === 1'b0) lowcnt++;
        @(negedge clock);
      end
      chk($sformatf("tx_line_bit%0d_byte%02h", b, d), 32'(ok), 1);
    end
    chk("tx_ready_low_cycles", lowcnt, n * D);
    chk("tx_ready_back", 32'(tx_ready[s]), 1);
    chk("tx_line_idle", 32'(out_l[s]), 1);
  endtask

  // Console-style line driver; records the entry the receiver should produce.
  task automatic line_frame(input int s, input logic [7:0] d, input logic bad_par,
                            input int stop_low);
    ent_t e;
    drv[s] = 1'b0;
    repeat (D) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      drv[s] = d[i];
      repeat (D) @(negedge clock);
    end
    if (s == 1) begin
      drv[s] = even_par(d) ^ bad_par;
      repeat (D) @(negedge clock);
    end
    if (stop_low > 0) begin
      drv[s] = 1'b0;
      repeat (stop_low) @(negedge clock);
    end
    drv[s] = 1'b1;
    repeat (D + 4) @(negedge clock);
    e = {d, (s == 1) && bad_par, stop_low > 0};
    if (s == 0) begin
      if (exp_q0.size() < DEPTH) exp_q0.push_back(e);
      else exp_ovr0++;
    end else exp_q1.push_back(e);
  endtask

  // Wait (bounded) for the FIFO head, compare it with the model, then pop.
  task automatic rx_pop(input int s, input string tag);
    ent_t e;
    for (int i = 0; i < 400 && rx_valid[s] !== 1'b1; i++) @(negedge clock);
    chk({tag, "_valid"}, 32'(rx_valid[s]), 1);
    if (s == 0) e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 10'h3ff;
    else        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 10'h3ff;
    chk(tag, 32'({rx_bits[s], pe[s], fe[s]}), 32'(e));
    rx_ready[s] = 1'b1;
    @(negedge clock);
    rx_ready[s] = 1'b0;
  endtask

  initial begin
    logic [7:0] lb_bytes [5];
    logic [7:0] r;
    for (int s = 0; s < 2; s++) begin
      tx_valid[s] = 1'b0;
      tx_bits[s]  = '0;
      rx_ready[s] = 1'b0;
      drv[s]      = 1'b1;
    end
    lb = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_out%0d", s),      32'(out_l[s]), 1);
      chk($sformatf("rst_tx_ready%0d", s), 32'(tx_ready[s]), 1);
      chk($sformatf("rst_rx_valid%0d", s), 32'(rx_valid[s]), 0);
      chk($sformatf("rst_pe%0d", s),       32'(pe[s]), 0);
      chk($sformatf("rst_fe%0d", s),       32'(fe[s]), 0);
      chk($sformatf("rst_ovr%0d", s),      32'(ovr[s]), 0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 8N1 transmit: fixed pattern then random bytes
    tx_frame(0, 8'hA5);
    tx_frame(0, 8'($urandom_range(0, 255)));
    tx_frame(0, 8'($urandom_range(0, 255)));

    // 8E1 loopback
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'h55;
    lb_bytes[3] = 8'($urandom_range(0, 255));
    lb_bytes[4] = 8'($urandom_range(0, 255));
    lb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_frame(1, lb_bytes[i]);
      exp_q1.push_back({lb_bytes[i], 2'b00});
      rx_pop(1, $sformatf("loopback_%0d", i));
    end
    lb = 1'b0;
    repeat (5) @(negedge clock);

    // Parity error, then a clean random frame
    line_frame(1, 8'h01, 1'b1, 0);
    rx_pop(1, "parity_err_entry");
    line_frame(1, 8'($urandom_range(0, 255)), 1'b0, 0);
    rx_pop(1, "parity_ok_entry");

    // Stop bit held low 30 cycles, line high, then a clean 0x3C
    line_frame(1, 8'($urandom_range(0, 255)), 1'b0, 30);
    repeat (20) @(negedge clock);
    line_frame(1, 8'h3C, 1'b0, 0);
    rx_pop(1, "framing_err_entry");
    rx_pop(1, "after_break_entry");
    repeat (5) @(negedge clock);
    chk("no_spurious_after_break", 32'(rx_valid[1]), 0);

    // Overrun: five frames into a depth-4 FIFO with no pops
    for (int i = 0; i < 5; i++) begin
      line_frame(0, 8'(8'h10 + i), 1'b0, 0);
      if (i == 3) chk("no_overrun_before_full", ovr_cnt0, exp_ovr0);
    end
    chk("overrun_pulse_count", ovr_cnt0, exp_ovr0);
    chk("overrun_expected_once", exp_ovr0, 1);
    for (int i = 0; i < 4; i++) rx_pop(0, $sformatf("fifo_pop_%0d", i));
    repeat (2) @(negedge clock);
    chk("fifo_empty_after_pops", 32'(rx_valid[0]), 0);

    // 3-cycle glitch must not start a frame
    drv[0] = 1'b0;
    repeat (3) @(negedge clock);
    drv[0] = 1'b1;
    repeat (40) @(negedge clock);
    chk("glitch_no_push", 32'(rx_valid[0]), 0);
    r = 8'($urandom_range(0, 255));
    line_frame(0, r, 1'b0, 0);
    rx_pop(0, "rx_8n1_random");

    // Reset in the middle of a transmitted 0x00
    tx_bits[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    @(negedge clock);
    tx_valid[0] = 1'b0;
    repeat (25) @(negedge clock);
    chk("tx_mid_frame_low", 32'(out_l[0]), 0);
    #2 reset = 1'b0;
    #1;
    chk("reset_async_out", 32'(out_l[0]), 1);
    chk("reset_tx_ready", 32'(tx_ready[0]), 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_tx_ready", 32'(tx_ready[0]), 1);
    chk("post_reset_out", 32'(out_l[0]), 1);
    chk("no_overrun_on_8e1", ovr_cnt1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: observed timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
